// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer: opcodes, condition codes,
// FSM state encoding and instruction field positions.
package cpu_pkg;

  localparam logic [3:0] OP_LDR  = 4'b1100;
  localparam logic [3:0] OP_STR  = 4'b1101;
  localparam logic [3:0] OP_B    = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_t;

  localparam int COND_MSB = 31, COND_LSB = 28;
  localparam int OPC_MSB  = 27, OPC_LSB  = 24;
  localparam int S_BIT    = 23;
  localparam int DEST_MSB = 22, DEST_LSB = 19;
  localparam int SRC2_MSB = 18, SRC2_LSB = 15;
  localparam int SRC1_MSB = 14, SRC1_LSB = 11;
  localparam int SHR_MSB  = 10, SHR_LSB  = 6;
  localparam int MOV_MSB  = 18, MOV_LSB  = 3;

  function automatic logic is_alu(input logic [3:0] opc);
    return !(opc == OP_LDR || opc == OP_STR || opc == OP_B || opc == OP_HALT);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// ARM-style condition check of an instruction's cond field against {N,Z,C,V}.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flag,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = flag;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch, conditional decode, execute,
// optional memory access and register write-back.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic [31:0]     Instr,
  input  logic            Mem_Ready,
  input  logic [15:0]     Mem_Addr,
  input  logic [3:0]      New_Flag,
  output logic            Ram_Enable,
  output logic            Ram_RW,
  output logic [15:0]     Ram_Address,
  output logic            Reg_We,
  output logic            Mem_Enable,
  output logic [3:0]      Flag,
  output logic [PC_W-1:0] PC,
  output logic [31:0]     IR,
  output logic            Busy,
  output logic            Halted
);
  state_t     state;
  logic [3:0] opc;
  logic       pass;

  assign opc = IR[OPC_MSB:OPC_LSB];

  cond_eval u_cond (
    .cond (IR[COND_MSB:COND_LSB]),
    .flag (Flag),
    .pass (pass)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_IDLE;
      PC    <= RESET_PC;
      IR    <= '0;
      Flag  <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (Start) state <= ST_FETCH;
        ST_FETCH: if (Mem_Ready) begin
          IR    <= Instr;
          state <= ST_DECODE;
        end
        ST_DECODE: if (pass) state <= ST_EXEC;
        else begin
          PC    <= PC + PC_W'(1);
          state <= ST_FETCH;
        end
        ST_EXEC: begin
          case (opc)
            OP_LDR, OP_STR: state <= ST_MEM;
            OP_B: begin
              PC    <= IR[MOV_LSB +: PC_W];
              state <= ST_FETCH;
            end
            OP_HALT: state <= ST_HALT;
            default: begin
              if (IR[S_BIT]) Flag <= New_Flag;
              PC    <= PC + PC_W'(1);
              state <= ST_FETCH;
            end
          endcase
        end
        ST_MEM: if (Mem_Ready) begin
          if (opc == OP_LDR) state <= ST_WB;
          else begin
            PC    <= PC + PC_W'(1);
            state <= ST_FETCH;
          end
        end
        ST_WB: begin
          PC    <= PC + PC_W'(1);
          state <= ST_FETCH;
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  // Strobes decode from state (and IR) only, so the async reset clears them at once.
  always_comb begin
    Ram_Enable  = (state == ST_FETCH) || (state == ST_MEM);
    Ram_RW      = (state == ST_FETCH) || (state == ST_MEM && opc == OP_LDR);
    Ram_Address = '0;
    if (state == ST_FETCH)    Ram_Address = 16'(PC);
    else if (state == ST_MEM) Ram_Address = Mem_Addr;
    Reg_We      = (state == ST_EXEC && is_alu(opc)) || (state == ST_WB);
    Mem_Enable  = (state == ST_MEM);
    Busy        = (state != ST_IDLE) && (state != ST_HALT);
    Halted      = (state == ST_HALT);
  end
endmodule
